// File: rtl/pes_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pes_rr_pkg
//  Description : Shared definitions for the round-robin arbiter datapath.
//                Requester count, requester-ID width, grant-mux FSM state
//                encoding and grant-vector helper functions.
//  Revision    : 1.0  initial release
// ============================================================================
package pes_rr_pkg;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN  = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   // Index of the (single) set bit of a one-hot vector; 0 for an all-zero vector.
   function automatic logic [IDW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [IDW-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) begin
            idx = IDW'(i);
         end
      end
      return idx;
   endfunction

   // True when more than one bit is set: clearing the lowest set bit leaves
   // something behind only if a second bit was present.
   function automatic logic multi_hot(input logic [NREQ-1:0] v);
      return (v & (v - NREQ'(1))) != '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pes_rr_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pes_rr_skid_fifo
//  Description : Generic 2-entry valid/ready FIFO. The head is registered, so
//                a pushed word is visible on the output one cycle later.
//                A push is accepted while full if the head is popped in the
//                same cycle.
//  Ports       : clk, rst (async, active-low)
//                i_vld / i_dat / o_rdy  : write side
//                o_vld / o_dat / i_rdy  : read side
//  Revision    : 1.0  initial release
// ============================================================================
module pes_rr_skid_fifo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_vld,
   input  logic [W-1:0] i_dat,
   output logic         o_rdy,
   output logic         o_vld,
   output logic [W-1:0] o_dat,
   input  logic         i_rdy
);

   logic [W-1:0] mem0_q, mem0_d;
   logic [W-1:0] mem1_q, mem1_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         w_push;
   logic         w_pop;

   assign o_vld  = (cnt_q != 2'd0);
   assign o_dat  = rd_ptr_q ? mem1_q : mem0_q;
   // When full, the slot being written is the one the head pop releases.
   assign o_rdy  = (cnt_q != 2'd2) || i_rdy;
   assign w_pop  = o_vld && i_rdy;
   assign w_push = i_vld && o_rdy;

   always_comb begin
      mem0_d   = mem0_q;
      mem1_d   = mem1_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (w_push) begin
         if (wr_ptr_q) begin
            mem1_d = i_dat;
         end else begin
            mem0_d = i_dat;
         end
         wr_ptr_d = ~wr_ptr_q;
      end
      if (w_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({w_push, w_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem0_q   <= '0;
         mem1_q   <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         mem0_q   <= mem0_d;
         mem1_q   <= mem1_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pes_rr_grant_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pes_rr_grant_mux
//  Description : Grant-driven data mux behind the 4-requester round-robin
//                arbiter. Forwards the current owner's beats, tagged with the
//                owner ID, through a 2-entry skid FIFO to one target port;
//                reports per-tenure beat counts and latches grant-protocol
//                violations.
//  Ports       : clk, rst (async, active-low)
//                gnt0..3, vld0..3, dat0..3 in ; rdy0..3 out  (requester side)
//                tgt_vld, tgt_dat, tgt_id out ; tgt_rdy in   (target side)
//                ten_done, ten_id, ten_beats out             (tenure report)
//                gnt_err out                                 (sticky error)
//  Revision    : 1.0  initial release
// ============================================================================
module pes_rr_grant_mux
   import pes_rr_pkg::*;
#(
   parameter int DW = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          gnt0,
   input  logic          gnt1,
   input  logic          gnt2,
   input  logic          gnt3,
   input  logic          vld0,
   input  logic          vld1,
   input  logic          vld2,
   input  logic          vld3,
   input  logic [DW-1:0] dat0,
   input  logic [DW-1:0] dat1,
   input  logic [DW-1:0] dat2,
   input  logic [DW-1:0] dat3,
   output logic          rdy0,
   output logic          rdy1,
   output logic          rdy2,
   output logic          rdy3,
   output logic          tgt_vld,
   output logic [DW-1:0] tgt_dat,
   output logic [1:0]    tgt_id,
   input  logic          tgt_rdy,
   output logic          ten_done,
   output logic [1:0]    ten_id,
   output logic [CW-1:0] ten_beats,
   output logic          gnt_err
);

   localparam int FW = IDW + DW;

   logic [NREQ-1:0] w_gnt;
   logic [NREQ-1:0] w_vld;
   logic [NREQ-1:0] w_rdy;
   logic [DW-1:0]   w_dat [NREQ];

   state_e          state_q, state_d;
   logic [IDW-1:0]  owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ten_done_q, ten_done_d;
   logic [IDW-1:0]  ten_id_q, ten_id_d;
   logic [CW-1:0]   ten_beats_q, ten_beats_d;
   logic            gnt_err_q, gnt_err_d;

   logic            w_fifo_in_rdy;
   logic            w_accept;
   logic [FW-1:0]   w_push_dat;
   logic [FW-1:0]   w_head;
   logic            w_multi;
   logic            w_any;
   logic [IDW-1:0]  w_gnt_idx;
   logic [CW-1:0]   w_cnt_acc;

   assign w_gnt    = {gnt3, gnt2, gnt1, gnt0};
   assign w_vld    = {vld3, vld2, vld1, vld0};
   assign w_dat[0] = dat0;
   assign w_dat[1] = dat1;
   assign w_dat[2] = dat2;
   assign w_dat[3] = dat3;

   // Ready depends only on registered ownership, the live grant and FIFO
   // space; no requester valid feeds back into it.
   for (genvar n = 0; n < NREQ; n++) begin : g_rdy
      assign w_rdy[n] = (state_q == ST_OWN) && (owner_q == IDW'(n)) &&
                        w_gnt[n] && w_fifo_in_rdy;
   end

   assign rdy0 = w_rdy[0];
   assign rdy1 = w_rdy[1];
   assign rdy2 = w_rdy[2];
   assign rdy3 = w_rdy[3];

   // Only the owner can be ready, so the owner's data is the pushed payload.
   assign w_accept   = |(w_vld & w_rdy);
   assign w_push_dat = {owner_q, w_dat[owner_q]};

   pes_rr_skid_fifo #(
      .W (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .i_vld (w_accept),
      .i_dat (w_push_dat),
      .o_rdy (w_fifo_in_rdy),
      .o_vld (tgt_vld),
      .o_dat (w_head),
      .i_rdy (tgt_rdy)
   );

   assign tgt_id  = w_head[FW-1:DW];
   assign tgt_dat = w_head[DW-1:0];

   assign w_multi   = multi_hot(w_gnt);
   assign w_any     = |w_gnt;
   assign w_gnt_idx = onehot_to_idx(w_gnt);

   // Beat count including this cycle's accept, held at all-ones once reached.
   assign w_cnt_acc = (w_accept && (cnt_q != {CW{1'b1}})) ? cnt_q + CW'(1) : cnt_q;

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      ten_done_d  = 1'b0;
      ten_id_d    = ten_id_q;
      ten_beats_d = ten_beats_q;
      gnt_err_d   = gnt_err_q;
      case (state_q)
         ST_IDLE: begin
            if (w_multi) begin
               state_d   = ST_ERR;
               gnt_err_d = 1'b1;
            end else if (w_any) begin
               state_d = ST_OWN;
               owner_d = w_gnt_idx;
               cnt_d   = '0;
            end
         end
         ST_OWN: begin
            if (w_multi) begin
               state_d   = ST_ERR;
               gnt_err_d = 1'b1;
            end else if (w_gnt[owner_q]) begin
               cnt_d = w_cnt_acc;
            end else begin
               ten_done_d  = 1'b1;
               ten_id_d    = owner_q;
               ten_beats_d = w_cnt_acc;
               cnt_d       = '0;
               // A grant handed straight to another requester starts the
               // next tenure without passing through IDLE.
               if (w_any) begin
                  owner_d = w_gnt_idx;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_ERR: begin
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         cnt_q       <= '0;
         ten_done_q  <= 1'b0;
         ten_id_q    <= '0;
         ten_beats_q <= '0;
         gnt_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         ten_done_q  <= ten_done_d;
         ten_id_q    <= ten_id_d;
         ten_beats_q <= ten_beats_d;
         gnt_err_q   <= gnt_err_d;
      end
   end

   assign ten_done  = ten_done_q;
   assign ten_id    = ten_id_q;
   assign ten_beats = ten_beats_q;
   assign gnt_err   = gnt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pes_rr_grant_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pes_rr_grant_mux
//  Description : Self-checking bench for pes_rr_grant_mux (DW=8, CW=3).
//                Directed scenarios with hand-derived cycle tables, then a
//                randomized run against a queue-based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pes_rr_grant_mux;

   localparam int DW  = 8;
   localparam int CW  = 3;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [3:0]    gnt = '0;
   logic [3:0]    vld = '0;
   logic [DW-1:0] dat [4];
   logic [3:0]    rdy;
   logic          tgt_vld;
   logic [DW-1:0] tgt_dat;
   logic [1:0]    tgt_id;
   logic          tgt_rdy = 1'b0;
   logic          ten_done;
   logic [1:0]    ten_id;
   logic [CW-1:0] ten_beats;
   logic          gnt_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pes_rr_grant_mux #(
      .DW (DW),
      .CW (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .gnt0      (gnt[0]),
      .gnt1      (gnt[1]),
      .gnt2      (gnt[2]),
      .gnt3      (gnt[3]),
      .vld0      (vld[0]),
      .vld1      (vld[1]),
      .vld2      (vld[2]),
      .vld3      (vld[3]),
      .dat0      (dat[0]),
      .dat1      (dat[1]),
      .dat2      (dat[2]),
      .dat3      (dat[3]),
      .rdy0      (rdy[0]),
      .rdy1      (rdy[1]),
      .rdy2      (rdy[2]),
      .rdy3      (rdy[3]),
      .tgt_vld   (tgt_vld),
      .tgt_dat   (tgt_dat),
      .tgt_id    (tgt_id),
      .tgt_rdy   (tgt_rdy),
      .ten_done  (ten_done),
      .ten_id    (ten_id),
      .ten_beats (ten_beats),
      .gnt_err   (gnt_err)
   );

   // Stimulus helper only: quiet inputs, pulse reset, return at posedge+1.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; gnt = '0; vld = '0; tgt_rdy = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; gnt = 4'b0010; vld = 4'hF; tgt_rdy = 1'b1;
      for (int n = 0; n < 4; n++) dat[n] = 8'hA0 + DW'(n);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (rdy !== 4'b0) begin n_errors++; $display("FAIL reset_rdy got=%b exp=0000", rdy); end
      n_checks++; if (tgt_vld !== 1'b0 || tgt_dat !== '0 || tgt_id !== 2'd0) begin
         n_errors++; $display("FAIL reset_tgt got vld=%b dat=%h id=%0d exp 0/00/0", tgt_vld, tgt_dat, tgt_id); end
      n_checks++; if (ten_done !== 1'b0 || ten_id !== 2'd0 || ten_beats !== '0) begin
         n_errors++; $display("FAIL reset_ten got done=%b id=%0d beats=%0d exp 0/0/0", ten_done, ten_id, ten_beats); end
      n_checks++; if (gnt_err !== 1'b0) begin n_errors++; $display("FAIL reset_gnt_err got=%b exp=0", gnt_err); end
      gnt = '0; vld = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (rdy !== 4'b0 || tgt_vld !== 1'b0) begin
         n_errors++; $display("FAIL post_reset_idle got rdy=%b vld=%b exp 0000/0", rdy, tgt_vld); end
   endtask

   task automatic test_single_tenure();
      logic [3:0]    e_rdy;
      logic [DW-1:0] e_dat;
      tgt_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         gnt = (i < 6) ? 4'b0010 : 4'b0000;
         vld = 4'b0010;
         dat[1] = 8'h10 + DW'(i);
         @(negedge clk);
         e_rdy = 4'b0; e_rdy[1] = (i >= 1 && i <= 5);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL single_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         n_checks++; if (tgt_vld !== (i >= 2 && i <= 6)) begin
            n_errors++; $display("FAIL single_tgt_vld cyc=%0d got=%b", i, tgt_vld); end
         if (i >= 2 && i <= 6) begin
            e_dat = 8'h10 + DW'(i - 1);
            n_checks++; if (tgt_dat !== e_dat || tgt_id !== 2'd1) begin
               n_errors++; $display("FAIL single_beat cyc=%0d got=%h/%0d exp=%h/1", i, tgt_dat, tgt_id, e_dat); end
         end
         n_checks++; if (ten_done !== (i == 7)) begin
            n_errors++; $display("FAIL single_ten_done cyc=%0d got=%b", i, ten_done); end
         if (i == 7) begin
            n_checks++; if (ten_id !== 2'd1 || ten_beats !== CW'(5)) begin
               n_errors++; $display("FAIL single_ten_report got id=%0d beats=%0d exp 1/5", ten_id, ten_beats); end
         end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] heads [12];
      logic [3:0]    e_rdy;
      heads = '{8'h00, 8'h00, 8'h41, 8'h41, 8'h41, 8'h41, 8'h42, 8'h45, 8'h46, 8'h47, 8'h00, 8'h00};
      for (int i = 0; i < 12; i++) begin
         gnt = (i < 8) ? 4'b0001 : 4'b0000;
         vld = 4'b0001;
         dat[0] = 8'h40 + DW'(i);
         tgt_rdy = (i >= 5);
         @(negedge clk);
         e_rdy = 4'b0; e_rdy[0] = (i == 1 || i == 2 || i == 5 || i == 6 || i == 7);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL bp_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         n_checks++; if (tgt_vld !== (heads[i] != 8'h00)) begin
            n_errors++; $display("FAIL bp_tgt_vld cyc=%0d got=%b", i, tgt_vld); end
         if (heads[i] != 8'h00) begin
            n_checks++; if (tgt_dat !== heads[i] || tgt_id !== 2'd0) begin
               n_errors++; $display("FAIL bp_head cyc=%0d got=%h/%0d exp=%h/0", i, tgt_dat, tgt_id, heads[i]); end
         end
         n_checks++; if (ten_done !== (i == 9)) begin
            n_errors++; $display("FAIL bp_ten_done cyc=%0d got=%b", i, ten_done); end
         if (i == 9) begin
            n_checks++; if (ten_id !== 2'd0 || ten_beats !== CW'(5)) begin
               n_errors++; $display("FAIL bp_ten_report got id=%0d beats=%0d exp 0/5", ten_id, ten_beats); end
         end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] heads [11];
      logic [3:0]    e_rdy;
      heads = '{8'h00, 8'h00, 8'h21, 8'h21, 8'h21, 8'h21, 8'h22, 8'h35, 8'h36, 8'h37, 8'h00};
      for (int i = 0; i < 11; i++) begin
         gnt = (i < 4) ? 4'b0100 : (i < 8) ? 4'b1000 : 4'b0000;
         vld = 4'b1100;
         dat[2] = 8'h20 + DW'(i);
         dat[3] = 8'h30 + DW'(i);
         tgt_rdy = (i >= 5);
         @(negedge clk);
         e_rdy = 4'b0;
         e_rdy[2] = (i == 1 || i == 2);
         e_rdy[3] = (i >= 5 && i <= 7);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL b2b_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         n_checks++; if (tgt_vld !== (heads[i] != 8'h00)) begin
            n_errors++; $display("FAIL b2b_tgt_vld cyc=%0d got=%b", i, tgt_vld); end
         if (heads[i] != 8'h00) begin
            n_checks++; if (tgt_dat !== heads[i] || tgt_id !== heads[i][5:4]) begin
               n_errors++; $display("FAIL b2b_head cyc=%0d got=%h/%0d exp=%h/%0d", i, tgt_dat, tgt_id, heads[i], heads[i][5:4]); end
         end
         n_checks++; if (ten_done !== (i == 5 || i == 9)) begin
            n_errors++; $display("FAIL b2b_ten_done cyc=%0d got=%b", i, ten_done); end
         if (i == 5) begin
            n_checks++; if (ten_id !== 2'd2 || ten_beats !== CW'(2)) begin
               n_errors++; $display("FAIL b2b_ten_old got id=%0d beats=%0d exp 2/2", ten_id, ten_beats); end
         end
         if (i == 9) begin
            n_checks++; if (ten_id !== 2'd3 || ten_beats !== CW'(3)) begin
               n_errors++; $display("FAIL b2b_ten_new got id=%0d beats=%0d exp 3/3", ten_id, ten_beats); end
         end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   task automatic test_saturation();
      logic [3:0]    e_rdy;
      logic [DW-1:0] e_dat;
      tgt_rdy = 1'b1;
      for (int i = 0; i < 14; i++) begin
         gnt = (i <= 10) ? 4'b0010 : 4'b0000;
         vld = 4'b0010;
         dat[1] = 8'h70 + DW'(i);
         @(negedge clk);
         e_rdy = 4'b0; e_rdy[1] = (i >= 1 && i <= 10);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL sat_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         if (i >= 2 && i <= 11) begin
            e_dat = 8'h70 + DW'(i - 1);
            n_checks++; if (tgt_vld !== 1'b1 || tgt_dat !== e_dat) begin
               n_errors++; $display("FAIL sat_beat cyc=%0d got=%b/%h exp=1/%h", i, tgt_vld, tgt_dat, e_dat); end
         end
         n_checks++; if (ten_done !== (i == 12)) begin
            n_errors++; $display("FAIL sat_ten_done cyc=%0d got=%b", i, ten_done); end
         if (i == 12) begin
            n_checks++; if (ten_id !== 2'd1 || ten_beats !== CW'(SAT)) begin
               n_errors++; $display("FAIL sat_ten_report got id=%0d beats=%0d exp 1/%0d", ten_id, ten_beats, SAT); end
         end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   task automatic test_grant_error();
      logic [DW-1:0] heads [10];
      logic [3:0]    e_rdy;
      heads = '{8'h00, 8'h00, 8'h51, 8'h51, 8'h51, 8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 10; i++) begin
         gnt = (i == 2) ? 4'b0101 : (i < 6) ? 4'b0001 : 4'b0000;
         vld = 4'b0101;
         dat[0] = 8'h50 + DW'(i);
         dat[2] = 8'hE0 + DW'(i);
         tgt_rdy = (i >= 4);
         @(negedge clk);
         e_rdy = 4'b0; e_rdy[0] = (i == 1 || i == 2);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL err_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         n_checks++; if (gnt_err !== (i >= 3)) begin
            n_errors++; $display("FAIL err_flag cyc=%0d got=%b", i, gnt_err); end
         n_checks++; if (tgt_vld !== (heads[i] != 8'h00)) begin
            n_errors++; $display("FAIL err_tgt_vld cyc=%0d got=%b", i, tgt_vld); end
         if (heads[i] != 8'h00) begin
            n_checks++; if (tgt_dat !== heads[i] || tgt_id !== 2'd0) begin
               n_errors++; $display("FAIL err_head cyc=%0d got=%h/%0d exp=%h/0", i, tgt_dat, tgt_id, heads[i]); end
         end
         n_checks++; if (ten_done !== 1'b0) begin
            n_errors++; $display("FAIL err_ten_done cyc=%0d got=%b exp=0", i, ten_done); end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   task automatic test_reset_mid_tenure();
      logic [DW-1:0] heads [6];
      logic [3:0]    e_rdy;
      do_reset();
      tgt_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         gnt = 4'b0010;
         vld = (i == 1) ? 4'b0010 : 4'b0000;
         dat[1] = 8'h6A;
         @(negedge clk);
         e_rdy = 4'b0; e_rdy[1] = (i == 1);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL rmt_pre_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         @(posedge clk);
         #1;
      end
      vld = 4'b0010;
      n_checks++; if (tgt_vld !== 1'b1 || tgt_dat !== 8'h6A) begin
         n_errors++; $display("FAIL rmt_buffered got vld=%b dat=%h exp 1/6a", tgt_vld, tgt_dat); end
      #2;
      rst = 1'b0;
      #1;
      n_checks++; if (tgt_vld !== 1'b0 || rdy !== 4'b0 || gnt_err !== 1'b0 || ten_done !== 1'b0) begin
         n_errors++; $display("FAIL rmt_async got vld=%b rdy=%b err=%b done=%b exp 0/0000/0/0",
                              tgt_vld, rdy, gnt_err, ten_done); end
      gnt = '0; vld = '0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         n_checks++; if (ten_done !== 1'b0 || tgt_vld !== 1'b0) begin
            n_errors++; $display("FAIL rmt_hold k=%0d got done=%b vld=%b exp 0/0", k, ten_done, tgt_vld); end
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      heads = '{8'h00, 8'h00, 8'h61, 8'h62, 8'h00, 8'h00};
      tgt_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         gnt = (i < 3) ? 4'b0010 : 4'b0000;
         vld = 4'b0010;
         dat[1] = 8'h60 + DW'(i);
         @(negedge clk);
         e_rdy = 4'b0; e_rdy[1] = (i == 1 || i == 2);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL rmt_rdy cyc=%0d got=%b exp=%b", i, rdy, e_rdy); end
         n_checks++; if (tgt_vld !== (heads[i] != 8'h00) || (heads[i] != 8'h00 && tgt_dat !== heads[i])) begin
            n_errors++; $display("FAIL rmt_head cyc=%0d got=%b/%h exp=%h", i, tgt_vld, tgt_dat, heads[i]); end
         n_checks++; if (ten_done !== (i == 4) || (i == 4 && ten_beats !== CW'(2))) begin
            n_errors++; $display("FAIL rmt_ten cyc=%0d got done=%b beats=%0d", i, ten_done, ten_beats); end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   task automatic test_random();
      logic [DW+1:0] m_q [$];
      int            m_mode;   // 0 idle, 1 owning, 2 error
      int            m_owner;
      int            m_cnt;
      bit            m_done;
      int            m_tid;
      int            m_tb;
      bit            m_err;
      int            cur;
      int            r;
      int            nhot;
      int            newid;
      bit            acc;
      logic [3:0]    e_rdy;
      do_reset();
      m_mode = 0; m_owner = 0; m_cnt = 0; m_done = 0; m_tid = 0; m_tb = 0; m_err = 0; cur = -1;
      for (int c = 0; c < 400; c++) begin
         r = int'($urandom_range(0, 99));
         if (cur < 0) begin
            if (r < 50) cur = int'($urandom_range(0, 3));
         end else if (r < 12) begin
            cur = -1;
         end else if (r < 24) begin
            cur = int'($urandom_range(0, 3));
         end
         gnt = '0;
         if (cur >= 0) gnt[cur] = 1'b1;
         if (c == 350) gnt = 4'b1010;
         vld = 4'($urandom);
         for (int n = 0; n < 4; n++) dat[n] = DW'($urandom);
         tgt_rdy = ($urandom_range(0, 99) < 60);
         @(negedge clk);
         e_rdy = '0;
         for (int n = 0; n < 4; n++)
            e_rdy[n] = (m_mode == 1) && (m_owner == n) && gnt[n] && (m_q.size() < 2 || tgt_rdy);
         n_checks++; if (rdy !== e_rdy) begin n_errors++; $display("FAIL rnd_rdy cyc=%0d got=%b exp=%b", c, rdy, e_rdy); end
         n_checks++; if (tgt_vld !== (m_q.size() != 0)) begin
            n_errors++; $display("FAIL rnd_tgt_vld cyc=%0d got=%b exp=%b", c, tgt_vld, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            n_checks++; if ({tgt_id, tgt_dat} !== m_q[0]) begin
               n_errors++; $display("FAIL rnd_head cyc=%0d got=%0d/%h exp=%0d/%h", c, tgt_id, tgt_dat,
                                    m_q[0][DW+1:DW], m_q[0][DW-1:0]); end
         end
         n_checks++; if (ten_done !== m_done) begin
            n_errors++; $display("FAIL rnd_ten_done cyc=%0d got=%b exp=%b", c, ten_done, m_done); end
         if (m_done) begin
            n_checks++; if (ten_id !== 2'(m_tid) || ten_beats !== CW'(m_tb)) begin
               n_errors++; $display("FAIL rnd_ten_report cyc=%0d got=%0d/%0d exp=%0d/%0d", c, ten_id, ten_beats, m_tid, m_tb); end
         end
         n_checks++; if (gnt_err !== m_err) begin
            n_errors++; $display("FAIL rnd_gnt_err cyc=%0d got=%b exp=%b", c, gnt_err, m_err); end
         // Advance the reference model by one clock.
         if (m_q.size() != 0 && tgt_rdy) void'(m_q.pop_front());
         acc = 1'b0;
         for (int n = 0; n < 4; n++) begin
            if (e_rdy[n] && vld[n]) begin
               m_q.push_back({2'(n), dat[n]});
               acc = 1'b1;
            end
         end
         nhot  = $countones(gnt);
         newid = 0;
         for (int n = 0; n < 4; n++) if (gnt[n]) newid = n;
         m_done = 1'b0;
         if (m_mode != 2 && nhot > 1) begin
            m_mode = 2; m_err = 1'b1;
         end else if (m_mode == 0 && nhot == 1) begin
            m_mode = 1; m_owner = newid; m_cnt = 0;
         end else if (m_mode == 1) begin
            if (gnt[m_owner]) begin
               if (acc && m_cnt < SAT) m_cnt++;
            end else begin
               m_done = 1'b1;
               m_tid  = m_owner;
               m_tb   = (acc && m_cnt < SAT) ? m_cnt + 1 : m_cnt;
               if (nhot == 1) begin
                  m_owner = newid; m_cnt = 0;
               end else begin
                  m_mode = 0;
               end
            end
         end
         @(posedge clk);
         #1;
      end
      gnt = '0; vld = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < 4; n++) dat[n] = '0;
      test_reset();
      test_single_tenure();
      test_backpressure();
      test_back_to_back();
      test_saturation();
      test_grant_error();
      test_reset_mid_tenure();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
